// File: rtl/vector_list_sequencer.sv
// Vector list sequencer: walks up to NSHAPES shape lists in an external
// vector ROM, applies a per-slot saturating signed translation, and streams
// move/draw points to the line drawer over a valid/ready handshake.
module vector_list_sequencer #(
  parameter int ADDRESSWIDTH = 16,
  parameter int COORDW       = 8,
  parameter int NSHAPES      = 4,
  parameter int MAX_PTS      = 64,
  localparam int DATAWIDTH   = 2*COORDW+2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              frame_start,
  input  logic [NSHAPES-1:0]                slot_en,
  input  logic [NSHAPES*ADDRESSWIDTH-1:0]   slot_base,
  input  logic [NSHAPES*(COORDW+1)-1:0]     slot_dx,
  input  logic [NSHAPES*(COORDW+1)-1:0]     slot_dy,
  output logic [ADDRESSWIDTH-1:0]           rom_addr,
  input  logic [DATAWIDTH-1:0]              rom_data,
  output logic                              vec_valid,
  input  logic                              vec_ready,
  output logic [COORDW-1:0]                 vec_x,
  output logic [COORDW-1:0]                 vec_y,
  output logic                              vec_draw,
  output logic                              busy,
  output logic                              frame_done,
  output logic                              err_overrun
);

  localparam int SLOTW = (NSHAPES > 1) ? $clog2(NSHAPES) : 1;
  localparam int CNTW  = $clog2(MAX_PTS + 1);
  localparam int OFFW  = COORDW + 1;

  typedef enum logic [2:0] {IDLE, SEL, FETCH, WAIT, EMIT, DONE} state_e;

  state_e                          state_q;
  logic [SLOTW-1:0]                idx_q;
  logic [CNTW-1:0]                 cnt_q;
  logic [NSHAPES-1:0]              en_q;
  logic [NSHAPES*ADDRESSWIDTH-1:0] base_q;
  logic [NSHAPES*OFFW-1:0]         dx_q;
  logic [NSHAPES*OFFW-1:0]         dy_q;
  logic [ADDRESSWIDTH-1:0]         rom_addr_q;
  logic [COORDW-1:0]               vec_x_q;
  logic [COORDW-1:0]               vec_y_q;
  logic                            vec_draw_q;
  logic                            vec_valid_q;
  logic                            busy_q;
  logic                            frame_done_q;
  logic                            err_overrun_q;

  // Saturating add of an unsigned coordinate and a signed offset; the extra
  // top bit of the sum flags a negative result.
  function automatic logic [COORDW-1:0] sat_add(input logic [COORDW-1:0] c,
                                                input logic [OFFW-1:0]   off);
    logic [COORDW+1:0] sum;
    sum = {2'b00, c} + {off[OFFW-1], off};
    if (sum[COORDW+1])   return '0;
    else if (sum[COORDW]) return '1;
    else                 return sum[COORDW-1:0];
  endfunction

  // Entry fields and the current slot's snapshot values
  logic [COORDW-1:0]       ent_x;
  logic [COORDW-1:0]       ent_y;
  logic [1:0]              ent_kind;
  logic                    ent_point;
  logic                    last_slot;
  logic [ADDRESSWIDTH-1:0] cur_base;
  logic [OFFW-1:0]         cur_dx;
  logic [OFFW-1:0]         cur_dy;
  logic [CNTW-1:0]         cnt_next;

  assign ent_x     = rom_data[DATAWIDTH-1 -: COORDW];
  assign ent_y     = rom_data[2 +: COORDW];
  assign ent_kind  = rom_data[1:0];
  assign ent_point = (ent_kind == 2'b01) || (ent_kind == 2'b10);
  assign last_slot = (idx_q == SLOTW'(NSHAPES-1));
  assign cur_base  = base_q[idx_q*ADDRESSWIDTH +: ADDRESSWIDTH];
  assign cur_dx    = dx_q[idx_q*OFFW +: OFFW];
  assign cur_dy    = dy_q[idx_q*OFFW +: OFFW];
  assign cnt_next  = cnt_q + CNTW'(1);

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the slot snapshot registers are reset along with the FSM; they
      // are a handful of flops, so there is no reason to leave them X.
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      en_q          <= '0;
      base_q        <= '0;
      dx_q          <= '0;
      dy_q          <= '0;
      rom_addr_q    <= '0;
      vec_x_q       <= '0;
      vec_y_q       <= '0;
      vec_draw_q    <= 1'b0;
      vec_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // register values from the start of the cycle.
      frame_done_q  <= 1'b0;
      err_overrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            en_q    <= slot_en;
            base_q  <= slot_base;
            dx_q    <= slot_dx;
            dy_q    <= slot_dy;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SEL;
          end
        end
        SEL: begin
          if (en_q[idx_q]) begin
            rom_addr_q <= cur_base;
            cnt_q      <= '0;
            state_q    <= FETCH;
          end else if (last_slot) begin
            frame_done_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            idx_q <= idx_q + SLOTW'(1);
          end
        end
        FETCH: state_q <= WAIT;
        WAIT: begin
          if (ent_point) begin
            vec_x_q     <= sat_add(ent_x, cur_dx);
            vec_y_q     <= sat_add(ent_y, cur_dy);
            vec_draw_q  <= ent_kind[1];
            vec_valid_q <= 1'b1;
            state_q     <= EMIT;
          end else if (last_slot) begin
            frame_done_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            idx_q   <= idx_q + SLOTW'(1);
            state_q <= SEL;
          end
        end
        EMIT: begin
          if (vec_ready) begin
            vec_valid_q <= 1'b0;
            rom_addr_q  <= rom_addr_q + ADDRESSWIDTH'(1);
            cnt_q       <= cnt_next;
            if (cnt_next == CNTW'(MAX_PTS)) begin
              err_overrun_q <= 1'b1;
              if (last_slot) begin
                frame_done_q <= 1'b1;
                state_q      <= DONE;
              end else begin
                idx_q   <= idx_q + SLOTW'(1);
                state_q <= SEL;
              end
            end else begin
              state_q <= FETCH;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr    = rom_addr_q;
  assign vec_x       = vec_x_q;
  assign vec_y       = vec_y_q;
  assign vec_draw    = vec_draw_q;
  assign vec_valid   = vec_valid_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign err_overrun = err_overrun_q;

endmodule
